// File: rtl/seq_det_pkg.sv
// -----------------------------------------------------------------------------
// seq_det_pkg
// Shared constants and elaboration-time helpers for the serial sequence
// detectors. The helpers build the KMP-style transition table so the
// detector never compares against stored history at run time.
//
// Contents:
//   DEF_PATTERN_1011 : default 4-bit pattern (MSB is the first bit received)
//   border_len       : longest proper prefix of a pattern that is also a suffix
//   next_state       : matched-prefix length after appending one bit
// Patterns are passed right-aligned in 16 bits; bit len-1 is the first bit.
// -----------------------------------------------------------------------------
package seq_det_pkg;

   localparam logic [3:0] DEF_PATTERN_1011 = 4'b1011;
   localparam int         MAX_SEQ_LEN      = 16;

   // Length of the longest proper prefix of the pattern that is also a
   // suffix of it; this is where an overlapping match resumes.
   function automatic int border_len(input logic [15:0] pattern, input int len);
      int   best;
      logic same;
      best = 0;
      for (int k = 1; k < len; k++) begin
         same = 1'b1;
         for (int j = 0; j < k; j++) begin
            if (pattern[4'(len - 1 - j)] != pattern[4'(k - 1 - j)]) begin
               same = 1'b0;
            end
         end
         if (same) begin
            best = k;
         end
      end
      return best;
   endfunction

   // Matched length after the matched prefix of length s is followed by bit x.
   // The result is capped at len-1, so a complete match folds back to the
   // border length.
   function automatic int next_state(input logic [15:0] pattern, input int len,
                                     input int s, input logic x);
      int   best;
      int   lim;
      int   pos;
      logic same;
      logic bitVal;
      best = 0;
      lim  = (s + 1 < len) ? s + 1 : len - 1;
      for (int k = 1; k <= lim; k++) begin
         same = 1'b1;
         for (int j = 0; j < k; j++) begin
            pos    = s + 1 - k + j;
            bitVal = (pos == s) ? x : pattern[4'(len - 1 - pos)];
            if (pattern[4'(len - 1 - j)] != bitVal) begin
               same = 1'b0;
            end
         end
         if (same) begin
            best = k;
         end
      end
      return best;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Saturating up-counter with synchronous clear. Once it reaches all-ones it
// holds there instead of wrapping, so a large count is never mistaken for a
// small one.
//
// Ports:
//   clk   : rising-edge clock
//   rst   : synchronous active-low reset (count <- 0)
//   clr   : synchronous clear (count <- 0)
//   inc   : add one this cycle unless already saturated
//   count : current count, W bits
// -----------------------------------------------------------------------------
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] count
);

   // Reset and clear both win over an increment; the all-ones check
   // makes the counter stick at its maximum.
   always_ff @(posedge clk) begin
      if (!rst || clr) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + W'(1);
      end
   end

endmodule

// File: rtl/mealy_seq_det.sv
// -----------------------------------------------------------------------------
// mealy_seq_det
// Parametrised Mealy serial sequence detector used as a frame-marker finder.
// The state is the number of pattern bits matched so far. Transitions come
// from a table built at elaboration with KMP semantics. Overlapping or
// non-overlapping detection is chosen at run time with ovl.
//
// Parameters:
//   SEQ_LEN : pattern length, 2..16
//   PATTERN : pattern bits, MSB is the first bit received
//   CNT_W   : detection counter width, at least 1
//
// Ports:
//   clk     : rising-edge clock
//   rst     : synchronous active-low reset
//   en      : bit-valid; x is consumed only when en=1
//   clr     : synchronous clear of match state and counter
//   ovl     : 1 = overlapping detection, 0 = non-overlapping
//   x       : serial data bit
//   z       : detect pulse in the cycle the last pattern bit is presented
//   det_cnt : saturating number of detections since reset/clear
//
// Build option:
//   MEALY_SEQ_DET_REG_OUT_EN : when defined, z comes from a flop and pulses
//                              one cycle after the final bit.
// -----------------------------------------------------------------------------
module mealy_seq_det
   import seq_det_pkg::*;
#(
   parameter int                 SEQ_LEN = 4,
   parameter logic [SEQ_LEN-1:0] PATTERN = DEF_PATTERN_1011,
   parameter int                 CNT_W   = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             clr,
   input  logic             ovl,
   input  logic             x,
   output logic             z,
   output logic [CNT_W-1:0] det_cnt
);

   localparam int          SW     = $clog2(SEQ_LEN);
   localparam int          NSTATE = 2 ** SW;
   localparam logic [15:0] PAT16  = 16'(PATTERN);
   localparam logic [SW-1:0] LAST   = SW'(SEQ_LEN - 1);
   localparam logic [SW-1:0] BORDER = SW'(border_len(PAT16, SEQ_LEN));

   // Out-of-range parameters stop elaboration.
   if ((SEQ_LEN < 2) || (SEQ_LEN > MAX_SEQ_LEN) || (CNT_W < 1)) begin : gBadParam
      $error("mealy_seq_det: SEQ_LEN must be 2..16 and CNT_W at least 1");
   end

   logic [SW-1:0] state;
   logic [SW-1:0] nextState;
   logic          matchHit;
   logic          zComb;
   logic [SW-1:0] nextTable [NSTATE][2];

   // Transition table is constant. Rows past SEQ_LEN-1 can never be reached
   // and fall back to 0 so every state code has a defined successor.
   for (genvar s = 0; s < NSTATE; s++) begin : gRow
      for (genvar b = 0; b < 2; b++) begin : gCol
         localparam int NS = (s < SEQ_LEN) ? next_state(PAT16, SEQ_LEN, s, 1'(b)) : 0;
         assign nextTable[s][b] = SW'(NS);
      end
   end

   // A match needs the last pattern bit presented while en is high in the
   // final state. Clear and reset both mask the pulse so a suppressed match
   // is never flagged.
   assign matchHit = en && (state == LAST) && (x == PATTERN[0]);
   assign zComb    = matchHit && !clr && rst;

   // Next-state logic. With en low the state holds. On a match, ovl
   // decides whether to resume from the pattern border or restart at zero.
   // This is the only place ovl is looked at.
   always_comb begin
      nextState = state;
      if (en) begin
         if (matchHit) begin
            nextState = ovl ? BORDER : '0;
         end else begin
            nextState = nextTable[state][x];
         end
      end
   end

   // State register. Reset and clear both restart matching from zero.
   always_ff @(posedge clk) begin
      if (!rst || clr) begin
         state <= '0;
      end else begin
         state <= nextState;
      end
   end

   // Detection counter. It has its own reset/clear priority, so only the
   // raw match is passed in.
   sat_counter #(
      .W(CNT_W)
   ) uDetCnt (
      .clk  (clk),
      .rst  (rst),
      .clr  (clr),
      .inc  (matchHit),
      .count(det_cnt)
   );

`ifdef MEALY_SEQ_DET_REG_OUT_EN
   logic zReg;

   // Registered output for consumers in other blocks. It is glitch-free
   // and one cycle late, and it is cleared by reset or clear.
   always_ff @(posedge clk) begin
      if (!rst || clr) begin
         zReg <= 1'b0;
      end else begin
         zReg <= zComb;
      end
   end

   assign z = zReg;
`else
   assign z = zComb;
`endif

endmodule

// File: doc/mealy_seq_det.md
Name: mealy_seq_det

Overview:
- Parametrised Mealy serial sequence detector; successor to the fixed 4-bit non-overlapping detectors.
- Detects a compile-time PATTERN of SEQ_LEN bits on a 1-bit serial stream.
- Overlapping vs non-overlapping detection is selected at run time.
- Adds input-enable gating, synchronous clear and a saturating detection counter; sits in front of control/status logic as a frame-marker finder.

Parameters:
- SEQ_LEN, 4, pattern length in bits (2..16).
- PATTERN, 4'b1011, pattern; MSB is the first bit received.
- CNT_W, 8, width of detection counter.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  reset, synchronous, active-low (rst=0 at a rising edge resets the block).
- en  input  1  bit-valid; x is consumed only when en=1.
- clr  input  1  synchronous clear of match state and counter; does not reset mode.
- ovl  input  1  1 = overlapping detection, 0 = non-overlapping.
- x  input  1  serial data bit.
- z  output  1  Mealy detect pulse, high in the cycle the last pattern bit is presented.
- det_cnt  output  CNT_W  number of detections since reset/clr; saturates.

Behaviour:
- State = number of pattern bits currently matched, 0..SEQ_LEN-1, held in a $clog2(SEQ_LEN)-bit register; reset/clr value 0.
- Next state for (state s, bit x) uses KMP semantics: the longest prefix of PATTERN that is a suffix of (matched prefix of length s followed by x).
- The fallback table is computed at elaboration by a constant function. No runtime comparison against history.
- Match: s==SEQ_LEN-1, en=1 and x==PATTERN[0] (the last bit). z=1 combinationally in that cycle.
  - Next state is the border length of PATTERN (longest proper prefix that is also a suffix) if ovl=1; 0 if ovl=0.
- ovl is sampled only on match cycles. Changing ovl mid-sequence has no other effect.
- en=0: state holds, z=0, counter holds; x is ignored.
- clr=1: z=0; state←0 and det_cnt←0 at the edge. clr overrides a simultaneous match, which is neither flagged nor counted.
- rst=0: identical to clr, and takes priority over clr and en. z=0 while rst=0; det_cnt=0 after the reset edge.
- det_cnt increments by 1 on each match edge. It holds at 2^CNT_W-1 and does not wrap.
- Latency: z is zero-latency (combinational from x, en and state); det_cnt updates one cycle after z.
- Pattern with no border (e.g. 1000): overlapping and non-overlapping behave identically.
- Elaboration error if SEQ_LEN<2, SEQ_LEN>16, or CNT_W<1.

Optional Feature:
- Macro: MEALY_SEQ_DET_REG_OUT_EN.
- Defined: z is taken from a flop, so it pulses one cycle after the final bit (glitch-free output for cross-block use).
  - The registered z is cleared by rst=0 or clr.
  - det_cnt timing is unchanged.
- Undefined: z is the combinational Mealy output described above.

Decomposition:
- Shared package seq_det_pkg holds:
  - constant function border_len(pattern, len);
  - constant function next_state(pattern, len, s, x);
  - default pattern constant DEF_PATTERN_1011.
- One natural sub-module: sat_counter (parametrised width, inc/clr, saturating), reused for det_cnt.

Test Plan:
- Reset: hold rst=0 for 2 cycles with x toggling -> z=0, det_cnt=0. Release, then feed 1,0,1,1 with en=1 -> z=1 on the 4th bit; det_cnt=1 the next cycle.
- Non-overlap, ovl=0, stream 0101101101010110 with en=1 every cycle -> z high on bits 5 and 15 only; final det_cnt=2.
- Overlap, ovl=1, same stream -> z high on bits 5, 8 and 15; final det_cnt=3.
- Enable gating: feed 1,0,1 with en=1, then 3 cycles en=0 with x=0, then x=1 with en=1 -> z=1 on that bit (state held through the gap).
- Clear and saturation:
  - clr=1 on the cycle the final '1' of 1011 arrives -> z=0, det_cnt=0.
  - With CNT_W=2, five matches -> det_cnt sticks at 3.
- Macro build: with MEALY_SEQ_DET_REG_OUT_EN defined, rerun the non-overlap stream -> z high on the cycles after bits 5 and 15.
